// File: rtl/regfile_wb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared types and helpers for the register-file write-back block.
//   - Entry layout (destination index, data, arrival stamp) as stored in each
//     per-source FIFO.
//   - Source identifiers used by the arbiter.
//   - age_older(): modular age comparison on arrival stamps.
// The entry layout is fixed by the WB_* constants below; the top-level
// parameters default to these and must be kept equal to them.
// ----------------------------------------------------------------------------
package regfile_wb_pkg;

   localparam int WB_NUM_REGS   = 8;
   localparam int WB_DATAW      = 32;
   localparam int WB_FIFO_DEPTH = 4;

   localparam int WB_REG_W = $clog2(WB_NUM_REGS);
   // Two extra bits beyond the FIFO index keep in-flight stamps well inside
   // half the counter range, so the modular compare never aliases.
   localparam int WB_AGE_W = $clog2(WB_FIFO_DEPTH) + 2;

   typedef logic [WB_REG_W-1:0] reg_idx_t;
   typedef logic [WB_AGE_W-1:0] age_t;

   typedef struct packed {
      reg_idx_t            rd;
      logic [WB_DATAW-1:0] data;
      age_t                age;
   } wb_entry_t;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // a is older than (or the same age as) b when b - a lands in the lower
   // half of the stamp range. Equal stamps return 1, which gives the ALU
   // priority when it is passed as a.
   function automatic logic age_older(input age_t a, input age_t b);
      age_t diff;
      diff = b - a;
      return (diff[WB_AGE_W-1] == 1'b0);
   endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small circular FIFO holding write-back entries for one execution source.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i         enqueue push_entry_i (caller guarantees not full)
//   push_entry_i   entry to enqueue
//   pop_i          dequeue the head (caller guarantees not empty)
//   head_o         oldest stored entry
//   count_o        number of stored entries
//   full_o/empty_o occupancy flags
//   valid_o        per-slot valid bits
//   dest_o         per-slot destination register, used for the pending mask
// ----------------------------------------------------------------------------
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int  DEPTH   = WB_FIFO_DEPTH,
   parameter type entry_t = wb_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  entry_t                     push_entry_i,
   input  logic                       pop_i,
   output entry_t                     head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [DEPTH-1:0]           valid_o,
   output reg_idx_t                   dest_o [DEPTH]
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Push and pop together leave the count unchanged.
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; slot validity comes from the
   // pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] offs;
         offs       = PTR_W'(i) - rd_ptr_q;
         valid_o[i] = (CNT_W'(offs) < count_q);
         dest_o[i]  = mem_q[i].rd;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// ----------------------------------------------------------------------------
// regfile_writeback
// Producer for the register file's single write port. ALU and load results
// arrive over valid/ready handshakes, are stamped with an arrival age and
// buffered in one FIFO per source, and at most one is written per cycle.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_reg/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_reg/mem_data   load result handshake
//   wr_reg_en/wr_reg/wr_reg_data           register-file write port
//   pending                                registers with a queued write
//   idle                                   both FIFOs empty
// ----------------------------------------------------------------------------
module regfile_writeback
   import regfile_wb_pkg::*;
#(
   parameter int NUMREGISTERS = WB_NUM_REGS,
   parameter int DATAW        = WB_DATAW,
   parameter int FIFO_DEPTH   = WB_FIFO_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [$clog2(NUMREGISTERS)-1:0] alu_reg,
   input  logic [DATAW-1:0]                alu_data,
   input  logic                            mem_valid,
   output logic                            mem_ready,
   input  logic [$clog2(NUMREGISTERS)-1:0] mem_reg,
   input  logic [DATAW-1:0]                mem_data,
   output logic                            wr_reg_en,
   output logic [$clog2(NUMREGISTERS)-1:0] wr_reg,
   output logic [DATAW-1:0]                wr_reg_data,
   output logic [NUMREGISTERS-1:0]         pending,
   output logic                            idle
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   wb_entry_t          alu_head, mem_head, alu_in, mem_in;
   logic [CNT_W-1:0]   alu_count, mem_count;
   logic               alu_full, mem_full, alu_empty, mem_empty;
   logic [FIFO_DEPTH-1:0] alu_vld, mem_vld;
   reg_idx_t           alu_dest [FIFO_DEPTH];
   reg_idx_t           mem_dest [FIFO_DEPTH];
   logic               alu_push, mem_push, alu_pop, mem_pop;

   age_t               age_q, age_d;
   logic               rr_q, rr_d;
   logic               sel;

   // Ready comes from registered occupancy only; a same-cycle pop does not
   // open a slot early.
   assign alu_ready = ~alu_full;
   assign mem_ready = ~mem_full;
   assign alu_push  = alu_valid & alu_ready;
   assign mem_push  = mem_valid & mem_ready;

   // Same-edge arrivals share the current stamp.
   assign alu_in = '{rd: alu_reg, data: alu_data, age: age_q};
   assign mem_in = '{rd: mem_reg, data: mem_data, age: age_q};
   assign age_d  = age_q + age_t'(alu_push | mem_push);

   wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_alu_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (alu_push),
      .push_entry_i(alu_in),
      .pop_i       (alu_pop),
      .head_o      (alu_head),
      .count_o     (alu_count),
      .full_o      (alu_full),
      .empty_o     (alu_empty),
      .valid_o     (alu_vld),
      .dest_o      (alu_dest)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_mem_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (mem_push),
      .push_entry_i(mem_in),
      .pop_i       (mem_pop),
      .head_o      (mem_head),
      .count_o     (mem_count),
      .full_o      (mem_full),
      .empty_o     (mem_empty),
      .valid_o     (mem_vld),
      .dest_o      (mem_dest)
   );

   // Arbitration: a lone non-empty source wins; equal destinations go to
   // the older head so register order is preserved; otherwise round-robin.
   always_comb begin
      sel  = SRC_ALU;
      rr_d = rr_q;
      if (!alu_empty && mem_empty) begin
         sel = SRC_ALU;
      end else if (alu_empty && !mem_empty) begin
         sel = SRC_MEM;
      end else if (!alu_empty && !mem_empty) begin
         if (alu_head.rd == mem_head.rd) begin
            sel = age_older(alu_head.age, mem_head.age) ? SRC_ALU : SRC_MEM;
         end else begin
            sel  = rr_q;
            rr_d = ~rr_q;
         end
      end
   end

   // No write leaves in a reset cycle; the queued entries are being dropped.
   assign wr_reg_en   = ~(alu_empty & mem_empty) & ~rst;
   assign alu_pop     = wr_reg_en & (sel == SRC_ALU);
   assign mem_pop     = wr_reg_en & (sel == SRC_MEM);
   assign wr_reg      = !wr_reg_en ? '0 : (sel == SRC_ALU) ? alu_head.rd   : mem_head.rd;
   assign wr_reg_data = !wr_reg_en ? '0 : (sel == SRC_ALU) ? alu_head.data : mem_head.data;

   always_comb begin
      pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (alu_vld[i]) pending[alu_dest[i]] = 1'b1;
         if (mem_vld[i]) pending[mem_dest[i]] = 1'b1;
      end
   end

   assign idle = (alu_count == '0) && (mem_count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
         rr_q  <= SRC_ALU;
      end else begin
         age_q <= age_d;
         if (wr_reg_en) rr_q <= rr_d;
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback
// Self-checking bench: a queue-based model of the two source FIFOs is stepped
// once per cycle and every DUT output is compared against it; directed
// scenarios add literal expectations on write order and final values.
// ----------------------------------------------------------------------------
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [2:0]  alu_reg, mem_reg;
   logic [31:0] alu_data, mem_data;
   logic        wr_reg_en;
   logic [2:0]  wr_reg;
   logic [31:0] wr_reg_data;
   logic [7:0]  pending;
   logic        idle;

   always #5 clk = ~clk;

   regfile_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_reg    (alu_reg),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_reg    (mem_reg),
      .mem_data   (mem_data),
      .wr_reg_en  (wr_reg_en),
      .wr_reg     (wr_reg),
      .wr_reg_data(wr_reg_data),
      .pending    (pending),
      .idle       (idle)
   );

   typedef struct {
      int unsigned rd;
      int unsigned data;
      int unsigned stamp;
   } m_entry_t;

   m_entry_t    qa[$], qm[$];       // model FIFOs, index 0 = head
   m_entry_t    acc_q[$];           // model accept order (ALU before mem per edge)
   m_entry_t    log_q[$];           // writes seen on the DUT port
   int unsigned m_age;
   int          m_rr;               // 0 = ALU next, 1 = mem next
   logic [31:0] dut_rf [8];         // register file as built from DUT writes
   int          n_vec, n_err;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_older(input int unsigned a, input int unsigned b);
      return ((b - a) & 32'd15) < 8;
   endfunction

   // Compare the current cycle's outputs with the model, then advance the
   // model across the coming rising edge.
   task automatic model_step();
      bit          a_rdy, m_rdy, have, e_en, rr_case;
      int          s;
      int unsigned e_reg, e_data;
      logic [7:0]  e_pend;
      m_entry_t    e;

      a_rdy   = qa.size() < 4;
      m_rdy   = qm.size() < 4;
      have    = (qa.size() != 0) || (qm.size() != 0);
      e_en    = !rst && have;
      s       = 0;
      rr_case = 0;
      if (qa.size() != 0 && qm.size() == 0)      s = 0;
      else if (qa.size() == 0 && qm.size() != 0) s = 1;
      else if (have) begin
         if (qa[0].rd == qm[0].rd) s = m_older(qa[0].stamp, qm[0].stamp) ? 0 : 1;
         else begin
            s       = m_rr;
            rr_case = 1;
         end
      end
      e_reg  = 0;
      e_data = 0;
      if (e_en) begin
         e_reg  = (s == 0) ? qa[0].rd   : qm[0].rd;
         e_data = (s == 0) ? qa[0].data : qm[0].data;
      end
      e_pend = '0;
      foreach (qa[i]) e_pend[qa[i].rd] = 1'b1;
      foreach (qm[i]) e_pend[qm[i].rd] = 1'b1;

      check("alu_ready",   64'(alu_ready),   64'(a_rdy));
      check("mem_ready",   64'(mem_ready),   64'(m_rdy));
      check("idle",        64'(idle),        64'(!have));
      check("pending",     64'(pending),     64'(e_pend));
      check("wr_reg_en",   64'(wr_reg_en),   64'(e_en));
      check("wr_reg",      64'(wr_reg),      64'(e_reg));
      check("wr_reg_data", 64'(wr_reg_data), 64'(e_data));

      if (wr_reg_en === 1'b1) begin
         log_q.push_back('{rd: int'(wr_reg), data: wr_reg_data, stamp: 0});
         dut_rf[wr_reg] = wr_reg_data;
      end

      if (rst) begin
         qa.delete();
         qm.delete();
         m_age = 0;
         m_rr  = 0;
      end else begin
         if (e_en) begin
            if (s == 0) void'(qa.pop_front());
            else        void'(qm.pop_front());
            if (rr_case) m_rr ^= 1;
         end
         if (alu_valid && a_rdy) begin
            e = '{rd: alu_reg, data: alu_data, stamp: m_age};
            qa.push_back(e);
            acc_q.push_back(e);
         end
         if (mem_valid && m_rdy) begin
            e = '{rd: mem_reg, data: mem_data, stamp: m_age};
            qm.push_back(e);
            acc_q.push_back(e);
         end
         if ((alu_valid && a_rdy) || (mem_valid && m_rdy)) m_age = (m_age + 1) & 32'd15;
      end
   endtask

   task automatic tick(input bit r,
                       input bit av, input int unsigned ar, input int unsigned ad,
                       input bit mv, input int unsigned mr, input int unsigned md);
      @(negedge clk);
      rst       = r;
      alu_valid = av;
      alu_reg   = 3'(ar);
      alu_data  = ad;
      mem_valid = mv;
      mem_reg   = 3'(mr);
      mem_data  = md;
      #1;
      model_step();
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_dut();
      tick(1, 0, 0, 0, 0, 0, 0);
      log_q.delete();
      acc_q.delete();
   endtask

   initial begin
      int  bp_n;
      bit  seen_full;
      int unsigned ad, md;
      int  exp_order [6];

      n_vec = 0;
      n_err = 0;
      m_age = 0;
      m_rr  = 0;
      foreach (dut_rf[i]) dut_rf[i] = '0;
      rst = 1'b1;
      alu_valid = 0; mem_valid = 0;
      alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
      repeat (2) @(posedge clk);
      reset_dut();

      // Reset state
      tick(0, 0, 0, 0, 0, 0, 0);
      check("rst_wr_reg_en", 64'(wr_reg_en), 64'd0);
      check("rst_pending",   64'(pending),   64'd0);
      check("rst_idle",      64'(idle),      64'd1);
      check("rst_alu_ready", 64'(alu_ready), 64'd1);
      check("rst_mem_ready", 64'(mem_ready), 64'd1);

      // Single ALU result: written one cycle after accept
      tick(0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      check("single_en",      64'(wr_reg_en),   64'd1);
      check("single_reg",     64'(wr_reg),      64'd3);
      check("single_data",    64'(wr_reg_data), 64'hDEADBEEF);
      check("single_pending", 64'(pending),     64'h08);
      tick(0, 0, 0, 0, 0, 0, 0);
      check("single_pend_clr", 64'(pending), 64'd0);
      check("single_idle",     64'(idle),    64'd1);

      // Same-register ordering across edges
      reset_dut();
      tick(0, 0, 0, 0, 1, 5, 32'h11);
      tick(0, 1, 5, 32'h22, 0, 0, 0);
      idle_ticks(3);
      check("order_n",    64'(log_q.size()), 64'd2);
      if (log_q.size() == 2) begin
         check("order_w0", 64'(log_q[0].data), 64'h11);
         check("order_w1", 64'(log_q[1].data), 64'h22);
      end
      check("order_r5", 64'(dut_rf[5]), 64'h22);

      // Same-edge tie: ALU first
      reset_dut();
      tick(0, 1, 2, 32'hA, 1, 2, 32'hB);
      idle_ticks(3);
      check("tie_n", 64'(log_q.size()), 64'd2);
      if (log_q.size() == 2) begin
         check("tie_w0", 64'(log_q[0].data), 64'hA);
         check("tie_w1", 64'(log_q[1].data), 64'hB);
      end
      check("tie_r2", 64'(dut_rf[2]), 64'hB);

      // Round-robin over distinct registers
      reset_dut();
      tick(0, 1, 1, 32'h101, 1, 4, 32'h204);
      tick(0, 1, 2, 32'h102, 1, 5, 32'h205);
      tick(0, 1, 3, 32'h103, 1, 6, 32'h206);
      idle_ticks(8);
      exp_order = '{1, 4, 2, 5, 3, 6};
      check("rr_n", 64'(log_q.size()), 64'd6);
      if (log_q.size() == 6)
         for (int i = 0; i < 6; i++) check("rr_reg", 64'(log_q[i].rd), 64'(exp_order[i]));

      // Backpressure: a lone ALU stream drains at one write per cycle
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         tick(0, 1, i, 32'h300 + i, 0, 0, 0);
         check("bp_alu_ready", 64'(alu_ready), 64'd1);
      end
      idle_ticks(3);
      // Both sources on one register: arrivals outpace the single write port
      log_q.delete();
      acc_q.delete();
      seen_full = 0;
      ad = 32'h400;
      md = 32'h500;
      for (int i = 0; i < 16; i++) begin
         bp_n = acc_q.size();
         tick(0, 1, 7, ad, 1, 7, md);
         if (alu_ready === 1'b0) seen_full = 1;
         // advance data only for sources the model accepted this edge
         if (acc_q.size() > bp_n && acc_q[bp_n].data == ad) ad++;
         if (acc_q.size() > bp_n && acc_q[acc_q.size()-1].data == md) md++;
      end
      idle_ticks(20);
      check("bp_alu_full_seen", 64'(seen_full), 64'd1);
      check("bp_count", 64'(log_q.size()), 64'(acc_q.size()));
      if (log_q.size() == acc_q.size())
         foreach (acc_q[i]) check("bp_order", 64'(log_q[i].data), 64'(acc_q[i].data));

      // Reset mid-operation
      reset_dut();
      tick(0, 1, 1, 32'h601, 1, 2, 32'h602);
      tick(0, 1, 3, 32'h603, 1, 4, 32'h604);
      tick(1, 0, 0, 0, 0, 0, 0);
      log_q.delete();
      tick(0, 0, 0, 0, 0, 0, 0);
      check("mr_wr_en",     64'(wr_reg_en), 64'd0);
      check("mr_pending",   64'(pending),   64'd0);
      check("mr_idle",      64'(idle),      64'd1);
      check("mr_alu_ready", 64'(alu_ready), 64'd1);
      check("mr_mem_ready", 64'(mem_ready), 64'd1);
      idle_ticks(5);
      check("mr_no_stale", 64'(log_q.size()), 64'd0);

      // Randomized traffic with occasional resets and register hot-spots
      for (int i = 0; i < 3000; i++) begin
         int unsigned hi;
         hi = (i % 600 < 300) ? 1 : 7;
         tick($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, hi), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, hi), $urandom);
      end
      idle_ticks(12);
      check("final_idle", 64'(idle), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side producer for the register file's single write port.
- Accepts completed results from two execution sources, the ALU and the memory-load unit, over valid/ready handshakes, and buffers each in a small per-source FIFO.
- Issues at most one write per cycle on wr_reg_en / wr_reg / wr_reg_data, with age-safe arbitration.
- Exports a per-register pending mask; issue logic uses it to stall reads of registers that still have queued writes.

Parameters:
- NUMREGISTERS, 8, number of architectural registers; index width is $clog2(NUMREGISTERS).
- DATAW, 32, result data width.
- FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU FIFO can accept
- alu_reg  in  $clog2(NUMREGISTERS)  ALU destination register
- alu_data  in  DATAW  ALU result
- mem_valid  in  1  load result present
- mem_ready  out  1  load FIFO can accept
- mem_reg  in  $clog2(NUMREGISTERS)  load destination register
- mem_data  in  DATAW  load data
- wr_reg_en  out  1  register-file write enable
- wr_reg  out  $clog2(NUMREGISTERS)  register-file write index
- wr_reg_data  out  DATAW  register-file write data
- pending  out  NUMREGISTERS  bit i set = a queued write to register i
- idle  out  1  both FIFOs empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset:
  - Both FIFOs are emptied, and the age counter and round-robin pointer are cleared.
  - Reset outputs: wr_reg_en=0, wr_reg=0, wr_reg_data=0, pending=0, idle=1, alu_ready=1, mem_ready=1.
  - Reset asserted mid-operation discards all queued entries; no write is issued in the reset cycle.
- Accept:
  - A transfer occurs on a rising edge with valid&&ready.
  - ready = FIFO count < FIFO_DEPTH, taken from registered state. There is no full-FIFO pass-through: a simultaneous dequeue does not raise ready in the same cycle.
  - Both sources may be accepted on the same edge.
- Age stamp:
  - Each accepted entry is tagged with a free-running arrival counter of width $clog2(FIFO_DEPTH)+2.
  - The counter increments once per cycle in which at least one entry is accepted.
  - Same-cycle arrivals share a stamp; on a tie, ALU is treated as older.
  - Age comparison is modular: a is older than b if (b - a) is in the lower half of the range.
- Issue (combinational from the FIFO heads; a registered head means 1-cycle latency from accept to write):
  - If exactly one FIFO is non-empty, its head is issued.
  - If both are non-empty and the head destinations are equal, the older head is issued.
  - Otherwise, round-robin selection. The pointer flips to the other source after each issue made under round-robin.
  - The issued head is popped on the same edge the register file commits it.
  - Outputs carry the issued entry's index and data; wr_reg_en is high whenever any FIFO is non-empty.
  - When not writing, wr_reg and wr_reg_data hold 0.
- pending:
  - OR over all valid entries in both FIFOs of onehot(dest).
  - Includes the entry being written this cycle; that bit clears on the commit edge unless another queued entry targets the same register.
  - Register 0 gets no special treatment.
- idle = both counts zero.
- Simultaneous accept and pop on one FIFO: the count is unchanged and the pointers both advance.

Decomposition:
- Shared package regfile_wb_pkg:
  - typedef wb_entry_t {reg index, data, age stamp}.
  - Constant SRC_ALU=0 and SRC_MEM=1.
  - Function age_older(a,b).
- Sub-module wb_fifo, instantiated twice:
  - Parameterised by depth and entry type.
  - Outputs: head, count, full, empty.
  - Exposes an entry-valid vector and the stored destinations so pending can be formed.

Test Plan:
- Single ALU result: alu_reg=3, alu_data=0xDEADBEEF accepted at edge 0 → cycle 1: wr_reg_en=1, wr_reg=3, wr_reg_data=0xDEADBEEF, pending=8'b0000_1000 → cycle 2: pending=0, idle=1.
- Backpressure: hold alu_valid for 6 cycles with no mem traffic → alu_ready stays 1 throughout (1 write per cycle drains). Then stall issue via a same-register older mem stream → after 4 queued entries alu_ready=0. No entry is lost or duplicated; the write order matches the accept order.
- Same-register ordering: mem_reg=5 data=0x11 at edge 0, alu_reg=5 data=0x22 at edge 1 → writes are 0x11 then 0x22 in consecutive cycles; register 5 ends at 0x22.
- Same-cycle tie: alu_reg=2 data=0xA and mem_reg=2 data=0xB accepted on one edge → ALU write first, then mem; final value 0xB.
- Round-robin fairness: both sources streaming distinct registers (ALU 1,2,3; mem 4,5,6) → issue order alternates ALU, mem, ALU, mem, ALU, mem.
- Reset mid-operation: 3 entries queued, rst=1 for one cycle → the next cycle shows wr_reg_en=0, pending=0, idle=1, both ready=1; no stale write appears afterward.
